led_seq_ctrl: RTL and testbench

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

---
 rtl/led_pkg.sv | 38 +++
 rtl/step_tick.sv | 39 +++
 rtl/led_seq_ctrl.sv | 113 +++++++++++
 tb/tb_led_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and defaults for the LED sequencer: controller states,
// divisor-select encodings and the default step divisors at 50 MHz.
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_0 = 2'd0;
  localparam logic [1:0] MODE_1 = 2'd1;
  localparam logic [1:0] MODE_2 = 2'd2;
  localparam logic [1:0] MODE_3 = 2'd3;

  localparam logic [31:0] DIV0_DEFAULT = 32'd25000;     // 2 kHz step
  localparam logic [31:0] DIV1_DEFAULT = 32'd2000;      // 25 kHz step
  localparam logic [31:0] DIV2_DEFAULT = 32'd5000000;   // 10 Hz step
  localparam logic [31:0] DIV3_DEFAULT = 32'd25000000;  // 2 Hz step

  // Map a 2-bit mode to one of the four divisors.
  function automatic logic [31:0] div_select(input logic [1:0]  mode,
                                             input logic [31:0] d0,
                                             input logic [31:0] d1,
                                             input logic [31:0] d2,
                                             input logic [31:0] d3);
    logic [31:0] d;
    case (mode)
      MODE_0:  d = d0;
      MODE_1:  d = d1;
      MODE_2:  d = d2;
      MODE_3:  d = d3;
      default: d = d0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/step_tick.sv
// Step counter: counts 1..div while enabled and emits a registered one-cycle
// tick when the count wraps. A divisor below 2 wraps on every enabled cycle.
// 'step' is the unregistered wrap condition, so the owner can register its
// own state from the very same condition as tick.
module step_tick (
  input  logic        fin,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] div,
  output logic        tick,
  output logic        step
);

  logic [31:0] count;

  // '>=' rather than '==' also covers div of 0 and 1.
  assign step = en && (count >= div);

  // Count register and registered tick; clear takes priority over counting.
  always_ff @(posedge fin or posedge reset) begin
    if (reset) begin
      count <= 32'd1;
      tick  <= 1'b0;
    end else if (clr) begin
      count <= 32'd1;
      tick  <= 1'b0;
    end else if (step) begin
      count <= 32'd1;
      tick  <= 1'b1;
    end else if (en) begin
      count <= count + 32'd1;
      tick  <= 1'b0;
    end else begin
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencer controller: IDLE/RUN/PAUSE FSM, rotate/bounce pattern
// register and the divisor configuration handshake.
// Handshake: a divisor change transfers on a cycle where cfg_valid and
// cfg_ready are both high; cfg_ready is low in RUN and the request is then
// simply not taken, so the requester keeps cfg_valid up until it sees ready.
module led_seq_ctrl
  import led_pkg::*;
#(
  parameter logic [31:0] DIV0 = DIV0_DEFAULT,
  parameter logic [31:0] DIV1 = DIV1_DEFAULT,
  parameter logic [31:0] DIV2 = DIV2_DEFAULT,
  parameter logic [31:0] DIV3 = DIV3_DEFAULT
) (
  input  logic       fin,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       pat,
  input  logic       cfg_valid,
  input  logic [1:0] cfg_mode,
  output logic       cfg_ready,
  output logic [7:0] led,
  output logic       tick,
  output logic       busy,
  output logic [1:0] state_dbg
);

  state_t      state, state_nxt;
  logic [31:0] div_q;
  logic        dir_left;
  logic        pat_q;
  logic        cnt_en, cnt_clr, step;
  logic        cfg_xfer;
  logic [7:0]  led_step;
  logic        dir_step;

  assign cfg_xfer  = cfg_valid && cfg_ready;
  assign state_dbg = state;

  // State register.
  always_ff @(posedge fin or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; stop wins over start in every state.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start && !stop) state_nxt = ST_RUN;
      ST_RUN:   if (stop)           state_nxt = ST_PAUSE;
      ST_PAUSE: if (stop)           state_nxt = ST_IDLE;
                else if (start)     state_nxt = ST_RUN;
      default:                      state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs and counter controls. The counter is frozen on the
  // RUN cycle that sees stop so nothing advances on the way into PAUSE.
  always_comb begin
    cfg_ready = (state != ST_RUN);
    busy      = (state != ST_IDLE);
    cnt_en    = (state == ST_RUN) && !stop;
    cnt_clr   = cfg_xfer || ((state == ST_PAUSE) && stop);
  end

  step_tick u_step_tick (
    .fin   (fin),
    .reset (reset),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .div   (div_q),
    .tick  (tick),
    .step  (step)
  );

  // Divisor register, loaded on a configuration transfer.
  always_ff @(posedge fin or posedge reset) begin
    if (reset)         div_q <= DIV0;
    else if (cfg_xfer) div_q <= div_select(cfg_mode, DIV0, DIV1, DIV2, DIV3);
  end

  // Next pattern value and direction for one step.
  always_comb begin
    led_step = {led[6:0], led[7]};
    dir_step = dir_left;
    if (pat_q) begin
      led_step = dir_left ? {led[6:0], 1'b0} : {1'b0, led[7:1]};
      if (led_step == 8'h80)      dir_step = 1'b0;
      else if (led_step == 8'h01) dir_step = 1'b1;
    end
  end

  // Pattern register: load on start from IDLE, clear on PAUSE->IDLE,
  // advance on the same step condition that raises tick.
  always_ff @(posedge fin or posedge reset) begin
    if (reset) begin
      led      <= 8'h00;
      dir_left <= 1'b1;
      pat_q    <= 1'b0;
    end else if ((state == ST_IDLE) && (state_nxt == ST_RUN)) begin
      led      <= 8'h01;
      dir_left <= 1'b1;
      pat_q    <= pat;
    end else if ((state == ST_PAUSE) && stop) begin
      led      <= 8'h00;
    end else if (step) begin
      led      <= led_step;
      dir_left <= dir_step;
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl with small divisors (4, 1, 3, 6).
module tb_led_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, pat = 1'b0, cfg_valid = 1'b0;
  logic [1:0] cfg_mode = 2'd0;
  logic       cfg_ready, tick, busy;
  logic [7:0] led;
  logic [1:0] state_dbg;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [39:0] exp_q[$];   // {cycle index, led value} of each expected tick

  // Reference model: run state, divisor, RUN cycles into current step,
  // number of steps since start, latched pattern.
  int m_state;             // 0 idle, 1 running, 2 paused
  int m_div, m_phase, m_k;
  bit m_pat;

  always #5 clk = ~clk;

  led_seq_ctrl #(.DIV0(32'd4), .DIV1(32'd1), .DIV2(32'd3), .DIV3(32'd6)) dut (
    .fin(clk), .reset(rst), .start(start), .stop(stop), .pat(pat),
    .cfg_valid(cfg_valid), .cfg_mode(cfg_mode), .cfg_ready(cfg_ready),
    .led(led), .tick(tick), .busy(busy), .state_dbg(state_dbg)
  );

  function automatic int div_of(input logic [1:0] m);
    case (m)
      2'd0: return 4;
      2'd1: return 1;
      2'd2: return 3;
      default: return 6;
    endcase
  endfunction

  // LED after k steps: rotate walks 8 positions, bounce walks a 14-step loop.
  function automatic logic [7:0] led_of(input int k, input bit p);
    int idx;
    logic [7:0] one;
    one = 8'h01;
    if (!p) idx = k % 8;
    else begin
      idx = k % 14;
      if (idx > 7) idx = 14 - idx;
    end
    return one << idx;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic model_edge();
    int ns, eff;
    bit hs;
    cyc++;
    if (rst) begin
      m_state = 0; m_div = 4; m_phase = 0; m_k = 0; m_pat = 0;
      return;
    end
    hs = cfg_valid && (m_state != 1);
    ns = m_state;
    case (m_state)
      0: if (start && !stop) begin
           ns = 1; m_k = 0; m_phase = 0; m_pat = pat;
         end
      1: if (stop) ns = 2;
         else begin
           eff = (m_div < 1) ? 1 : m_div;
           if (m_phase + 1 >= eff) begin
             m_phase = 0;
             m_k++;
             exp_q.push_back({32'(cyc), led_of(m_k, m_pat)});
           end else m_phase++;
         end
      default: if (stop) begin ns = 0; m_phase = 0; end
               else if (start) ns = 1;
    endcase
    if (hs) begin
      m_div = div_of(cfg_mode);
      m_phase = 0;
    end
    m_state = ns;
  endtask

  // One clock: model at the edge, level checks at the following negedge.
  task automatic tick_cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("led", {24'd0, led}, (m_state == 0) ? 32'd0 : {24'd0, led_of(m_k, m_pat)});
    check("busy", {31'd0, busy}, (m_state != 0) ? 32'd1 : 32'd0);
    check("cfg_ready", {31'd0, cfg_ready}, (m_state != 1) ? 32'd1 : 32'd0);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) tick_cycle();
  endtask

  task automatic pulse_start(input bit p);
    pat = p; start = 1'b1; tick_cycle(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick_cycle(); stop = 1'b0;
  endtask

  task automatic cfg_load(input logic [1:0] m);
    cfg_valid = 1'b1; cfg_mode = m; tick_cycle(); cfg_valid = 1'b0;
  endtask

  // Tick monitor: every tick must match the oldest expected tick in cycle and led.
  always @(negedge clk) begin
    logic [39:0] e;
    while (exp_q.size() > 0 && int'(exp_q[0][39:8]) < cyc) begin
      e = exp_q.pop_front();
      checks++; failures++;
      $display("FAIL missed_tick cyc=%0d expected_at=%0d", cyc, int'(e[39:8]));
    end
    if (tick === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_tick cyc=%0d actual=1 expected=0", cyc);
      end else begin
        e = exp_q.pop_front();
        if (int'(e[39:8]) != cyc || e[7:0] !== led) begin
          failures++;
          $display("FAIL tick_led cyc=%0d actual_led=%0h expected_led=%0h expected_cyc=%0d",
                   cyc, led, e[7:0], int'(e[39:8]));
        end
      end
    end
  end

  initial begin
    // Reset state
    cycles(3);
    check("reset_tick", {31'd0, tick}, 32'd0);
    rst = 1'b0;
    cycles(2);

    // Rotate with DIV0
    pulse_start(1'b0);
    cycles(40);
    pulse_stop(); pulse_stop();
    cycles(2);

    // Bounce with DIV0
    pulse_start(1'b1);
    cycles(70);
    pulse_stop(); pulse_stop();

    // DIV1 from IDLE, then a refused request while running
    cfg_load(2'd1);
    pulse_start(1'b0);
    cycles(10);
    cfg_valid = 1'b1; cfg_mode = 2'd3;
    cycles(5);
    cfg_valid = 1'b0;
    cycles(5);
    pulse_stop(); pulse_stop();
    cfg_load(2'd0);

    // Pause mid-step and resume
    pulse_start(1'b0);
    tick_cycle();
    pulse_stop();
    cycles(4);
    pulse_start(1'b0);
    cycles(8);
    pulse_stop(); pulse_stop();

    // start and stop together in IDLE, then in PAUSE
    start = 1'b1; stop = 1'b1;
    cycles(3);
    start = 1'b0; stop = 1'b0;
    pulse_start(1'b1);
    cycles(6);
    pulse_stop();
    start = 1'b1; stop = 1'b1;
    tick_cycle();
    start = 1'b0; stop = 1'b0;
    cycles(2);

    // Config transfer in PAUSE together with start
    pulse_start(1'b0);
    cycles(5);
    pulse_stop();
    cfg_valid = 1'b1; cfg_mode = 2'd2; start = 1'b1;
    tick_cycle();
    cfg_valid = 1'b0; start = 1'b0;
    cycles(12);

    // Asynchronous reset between edges mid-run, then restart on DIV0
    cfg_valid = 1'b1; cfg_mode = 2'd3;
    cycles(3);
    cfg_valid = 1'b0;
    pulse_stop(); pulse_stop();
    cfg_load(2'd3);
    pulse_start(1'b1);
    cycles(9);
    #2 rst = 1'b1;
    #1;
    check("async_led", {24'd0, led}, 32'd0);
    check("async_tick", {31'd0, tick}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    tick_cycle();
    rst = 1'b0;
    cycles(2);
    pulse_start(1'b0);
    cycles(14);
    pulse_stop(); pulse_stop();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      start     = ($urandom_range(0, 9) < 2);
      stop      = ($urandom_range(0, 24) == 0);
      pat       = $urandom_range(0, 1);
      cfg_valid = ($urandom_range(0, 15) == 0);
      cfg_mode  = 2'($urandom_range(0, 3));
      tick_cycle();
    end
    start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
    pulse_stop(); pulse_stop();
    cycles(3);
    check("pending_ticks", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
